// File: rtl/mux_rr_n_if.sv
// Handshake bundle for mux_rr_n: N valid/ready input channels merged into one registered output.
interface mux_rr_n_if #(
  parameter int unsigned W    = 32,
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = (N > 1) ? $clog2(N) : 1
);
  logic [N*W-1:0]  e_data;
  logic [N-1:0]    e_valid;
  logic [N-1:0]    e_ready;
  logic            modo;
  logic [SELW-1:0] sel;
  logic [W-1:0]    sal;
  logic            sal_valid;
  logic            sal_ready;
  logic [SELW-1:0] sal_idx;

  // Multiplexer side.
  modport slave (
    input  e_data, e_valid, modo, sel, sal_ready,
    output e_ready, sal, sal_valid, sal_idx
  );

  // Producers and consumer side.
  modport master (
    output e_data, e_valid, modo, sel, sal_ready,
    input  e_ready, sal, sal_valid, sal_idx
  );
endinterface

// File: rtl/mux_rr_n.sv
// N-channel, W-bit registered multiplexer with valid/ready on every port.
// modo=0 selects the channel named by sel; modo=1 arbitrates round-robin from ptr.
module mux_rr_n #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
) (
  input logic        clk,
  input logic        rst,
  mux_rr_n_if.slave  bus
);
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [W-1:0]    sal_q, sal_d;
  logic            sal_valid_q, sal_valid_d;
  logic [SELW-1:0] sal_idx_q, sal_idx_d;

  logic [SELW-1:0] grant;
  logic            grant_ok;
  logic [W-1:0]    grant_data;
  logic            accept;
  logic            xfer;

  // Output register can take a new word when empty or being drained this cycle.
  always_comb begin
    accept = !sal_valid_q || bus.sal_ready;
  end

  // Grant selection: fixed from sel, or first valid channel at or after ptr (wrapping).
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    if (bus.modo) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!grant_ok && bus.e_valid[i] && (32'(ptr_q) <= i)) begin
          grant    = SELW'(i);
          grant_ok = 1'b1;
        end
      end
      // Nothing valid from ptr upward, so search the channels below ptr.
      for (int unsigned i = 0; i < N; i++) begin
        if (!grant_ok && bus.e_valid[i]) begin
          grant    = SELW'(i);
          grant_ok = 1'b1;
        end
      end
    end else begin
      grant = bus.sel;
      // A sel value of N or above matches no channel and leaves grant_ok low.
      for (int unsigned i = 0; i < N; i++) begin
        if (32'(bus.sel) == i) begin
          grant_ok = bus.e_valid[i];
        end
      end
    end
  end

  // Data of the granted channel.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(grant) == i) begin
        grant_data = bus.e_data[i*W +: W];
      end
    end
  end

  // Ready goes to the granted channel only; held off entirely while in reset.
  always_comb begin
    xfer        = accept && grant_ok && !rst;
    bus.e_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.e_ready[i] = xfer && (32'(grant) == i);
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    sal_d       = sal_q;
    sal_valid_d = sal_valid_q;
    sal_idx_d   = sal_idx_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      sal_d       = grant_data;
      sal_idx_d   = grant;
      sal_valid_d = 1'b1;
      ptr_d       = (32'(grant) == N - 1) ? '0 : grant + 1'b1;
    end else if (accept) begin
      sal_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sal_q       <= '0;
      sal_valid_q <= 1'b0;
      sal_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      sal_q       <= sal_d;
      sal_valid_q <= sal_valid_d;
      sal_idx_q   <= sal_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.sal       = sal_q;
  assign bus.sal_valid = sal_valid_q;
  assign bus.sal_idx   = sal_idx_q;
endmodule

// File: tb/tb_mux_rr_n.sv
// Directed and random checks of mux_rr_n on N=4/W=32, N=3/W=16 and N=5/W=8 instances.
module tb_mux_rr_n;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mux_rr_n_if #(.W(32), .N(4)) bus4 ();
  mux_rr_n_if #(.W(16), .N(3)) bus3 ();
  mux_rr_n_if #(.W(8),  .N(5)) bus5 ();

  mux_rr_n #(.W(32), .N(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_rr_n #(.W(16), .N(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));
  mux_rr_n #(.W(8),  .N(5)) u5 (.clk(clk), .rst(rst), .bus(bus5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus4.modo = 1'b1; bus4.e_valid = 4'b1111; bus4.sal_ready = 1'b1;
    rst = 1'b1;
    #1;
    tests++; if (bus4.e_ready !== 4'b0000) begin fails++;
      $display("FAIL reset_ready: got %b expected 0000", bus4.e_ready); end
    tests++; if (bus4.sal_valid !== 1'b0 || bus4.sal !== 32'h0 || bus4.sal_idx !== 2'd0) begin
      fails++; $display("FAIL reset_out: got v=%b d=%h i=%0d expected v=0 d=0 i=0",
                        bus4.sal_valid, bus4.sal, bus4.sal_idx); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (bus4.e_ready !== 4'b0001) begin fails++;
      $display("FAIL reset_first_grant: got %b expected 0001", bus4.e_ready); end
    tick();
    tests++; if (bus4.sal_valid !== 1'b1 || bus4.sal !== 32'hCAFE0000 || bus4.sal_idx !== 2'd0)
      begin fails++; $display("FAIL reset_first_word: got v=%b d=%h i=%0d expected v=1 d=cafe0000 i=0",
                              bus4.sal_valid, bus4.sal, bus4.sal_idx); end
    tick();
    // Assert reset between edges while a word sits in the output register.
    #2 rst = 1'b1;
    #1;
    tests++; if (bus4.sal_valid !== 1'b0 || bus4.sal !== 32'h0 || bus4.sal_idx !== 2'd0 ||
                 bus4.e_ready !== 4'b0000) begin fails++;
      $display("FAIL reset_midstream: got v=%b d=%h i=%0d rdy=%b expected v=0 d=0 i=0 rdy=0000",
               bus4.sal_valid, bus4.sal, bus4.sal_idx, bus4.e_ready); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (bus4.e_ready !== 4'b0001) begin fails++;
      $display("FAIL reset_regrant: got %b expected 0001", bus4.e_ready); end
    tick();
    tests++; if (bus4.sal_idx !== 2'd0 || bus4.sal_valid !== 1'b1) begin fails++;
      $display("FAIL reset_regrant_idx: got i=%0d v=%b expected i=0 v=1",
               bus4.sal_idx, bus4.sal_valid); end
  endtask

  task automatic test_fixed();
    bus4.modo = 1'b0; bus4.sel = 2'd2; bus4.e_valid = 4'b1111; bus4.sal_ready = 1'b1;
    #1;
    tests++; if (bus4.e_ready !== 4'b0100) begin fails++;
      $display("FAIL fixed_ready: got %b expected 0100", bus4.e_ready); end
    tick();
    tests++; if (bus4.sal !== 32'hCAFE0002 || bus4.sal_idx !== 2'd2 || bus4.sal_valid !== 1'b1)
      begin fails++; $display("FAIL fixed_word: got d=%h i=%0d v=%b expected d=cafe0002 i=2 v=1",
                              bus4.sal, bus4.sal_idx, bus4.sal_valid); end
    bus4.sel = 2'd3; bus4.e_valid = 4'b0111;
    #1;
    tests++; if (bus4.e_ready !== 4'b0000) begin fails++;
      $display("FAIL fixed_idle_ready: got %b expected 0000", bus4.e_ready); end
    tick();
    tests++; if (bus4.sal_valid !== 1'b0 || bus4.sal !== 32'hCAFE0002 || bus4.sal_idx !== 2'd2)
      begin fails++; $display("FAIL fixed_drop: got v=%b d=%h i=%0d expected v=0 d=cafe0002 i=2",
                              bus4.sal_valid, bus4.sal, bus4.sal_idx); end
    bus4.e_valid = 4'b1111;
    #1;
    tests++; if (bus4.e_ready !== 4'b1000) begin fails++;
      $display("FAIL fixed_sel3_ready: got %b expected 1000", bus4.e_ready); end
    tick();
    tests++; if (bus4.sal !== 32'hCAFE0003 || bus4.sal_idx !== 2'd3) begin fails++;
      $display("FAIL fixed_sel3_word: got d=%h i=%0d expected d=cafe0003 i=3",
               bus4.sal, bus4.sal_idx); end
  endtask

  task automatic test_round_robin();
    logic [1:0] pair_seq [4];
    pair_seq[0] = 2'd1; pair_seq[1] = 2'd3; pair_seq[2] = 2'd1; pair_seq[3] = 2'd3;
    bus4.modo = 1'b1; bus4.e_valid = 4'b1111; bus4.sal_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++;
      if (bus4.sal_valid !== 1'b1 || bus4.sal_idx !== 2'(k % 4) ||
          bus4.sal !== 32'hCAFE0000 + 32'(k % 4)) begin fails++;
        $display("FAIL rr_all_%0d: got v=%b i=%0d d=%h expected v=1 i=%0d d=%h", k,
                 bus4.sal_valid, bus4.sal_idx, bus4.sal, k % 4, 32'hCAFE0000 + 32'(k % 4)); end
    end
    bus4.e_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (bus4.sal_valid !== 1'b1 || bus4.sal_idx !== pair_seq[k]) begin fails++;
        $display("FAIL rr_pair_%0d: got v=%b i=%0d expected v=1 i=%0d", k,
                 bus4.sal_valid, bus4.sal_idx, pair_seq[k]); end
    end
  endtask

  task automatic test_backpressure();
    bus4.modo = 1'b0; bus4.sel = 2'd1; bus4.e_valid = 4'b0010; bus4.sal_ready = 1'b1;
    bus4.e_data[32 +: 32] = 32'h12345678;
    do_reset();
    tick();
    tests++; if (bus4.sal !== 32'h12345678 || bus4.sal_idx !== 2'd1 || bus4.sal_valid !== 1'b1)
      begin fails++; $display("FAIL bp_load: got d=%h i=%0d v=%b expected d=12345678 i=1 v=1",
                              bus4.sal, bus4.sal_idx, bus4.sal_valid); end
    bus4.sal_ready = 1'b0; bus4.modo = 1'b1; bus4.e_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (bus4.e_ready !== 4'b0000) begin fails++;
        $display("FAIL bp_ready_%0d: got %b expected 0000", k, bus4.e_ready); end
      tick();
      tests++; if (bus4.sal !== 32'h12345678 || bus4.sal_idx !== 2'd1 || bus4.sal_valid !== 1'b1)
        begin fails++; $display("FAIL bp_hold_%0d: got d=%h i=%0d v=%b expected d=12345678 i=1 v=1",
                                k, bus4.sal, bus4.sal_idx, bus4.sal_valid); end
    end
    bus4.sal_ready = 1'b1;
    #1;
    // ptr still points past channel 1, so channel 2 wins.
    tests++; if (bus4.e_ready !== 4'b0100) begin fails++;
      $display("FAIL bp_release_ready: got %b expected 0100", bus4.e_ready); end
    tick();
    tests++; if (bus4.sal !== 32'hCAFE0002 || bus4.sal_idx !== 2'd2 || bus4.sal_valid !== 1'b1)
      begin fails++; $display("FAIL bp_release_word: got d=%h i=%0d v=%b expected d=cafe0002 i=2 v=1",
                              bus4.sal, bus4.sal_idx, bus4.sal_valid); end
    bus4.e_data[32 +: 32] = 32'hCAFE0001;
    bus4.e_valid = 4'b0000;
  endtask

  task automatic test_wrap_mode_switch();
    bus3.modo = 1'b1; bus3.e_valid = 3'b111; bus3.sal_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (bus3.sal_idx !== 2'(k) || bus3.sal !== 16'hB000 + 16'(k)) begin fails++;
        $display("FAIL wrap_rr_%0d: got i=%0d d=%h expected i=%0d d=%h", k, bus3.sal_idx,
                 bus3.sal, k, 16'hB000 + 16'(k)); end
    end
    bus3.modo = 1'b0; bus3.sel = 2'd3;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (bus3.e_ready !== 3'b000) begin fails++;
        $display("FAIL wrap_badsel_ready_%0d: got %b expected 000", k, bus3.e_ready); end
      tick();
      tests++; if (bus3.sal_valid !== 1'b0 || bus3.sal_idx !== 2'd2) begin fails++;
        $display("FAIL wrap_badsel_out_%0d: got v=%b i=%0d expected v=0 i=2", k,
                 bus3.sal_valid, bus3.sal_idx); end
    end
    bus3.modo = 1'b1;
    #1;
    tests++; if (bus3.e_ready !== 3'b001) begin fails++;
      $display("FAIL wrap_resume_ready: got %b expected 001", bus3.e_ready); end
    tick();
    tests++; if (bus3.sal_idx !== 2'd0 || bus3.sal !== 16'hB000 || bus3.sal_valid !== 1'b1)
      begin fails++; $display("FAIL wrap_resume_word: got i=%0d d=%h v=%b expected i=0 d=b000 v=1",
                              bus3.sal_idx, bus3.sal, bus3.sal_valid); end
    bus3.e_valid = 3'b000;
  endtask

  task automatic test_soak();
    logic [4:0] hs;
    logic       accept;
    logic       want;
    int         exp_idx[$];
    logic [7:0] exp_dat[$];
    int         waits[5];
    int         j;
    hs = '0;
    for (int i = 0; i < 5; i++) waits[i] = 0;
    bus5.e_valid = '0; bus5.modo = 1'b1; bus5.sel = '0; bus5.sal_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if (c % 64 == 0) begin
        bus5.modo = 1'($urandom_range(0, 1));
        bus5.sel  = 3'($urandom_range(0, 7));
      end
      // A channel keeps valid and data until its handshake completes.
      for (int i = 0; i < 5; i++) begin
        if (!(bus5.e_valid[i] && !hs[i])) begin
          bus5.e_valid[i]      = ($urandom_range(0, 1) == 1);
          bus5.e_data[i*8 +: 8] = 8'($urandom);
        end
      end
      bus5.sal_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      tests++; if ($countones(bus5.e_ready) > 1 || (bus5.e_ready & ~bus5.e_valid) != 5'b0)
        begin fails++; $display("FAIL soak_onehot c=%0d: got rdy=%b vld=%b expected one-hot subset",
                                c, bus5.e_ready, bus5.e_valid); end
      if (!bus5.modo && bus5.e_ready != 5'b0) begin
        tests++; if (bus5.sel >= 3'd5 || bus5.e_ready !== (5'b1 << bus5.sel)) begin fails++;
          $display("FAIL soak_fixed c=%0d: got rdy=%b expected sel=%0d", c, bus5.e_ready,
                   bus5.sel); end
      end
      accept = !bus5.sal_valid || bus5.sal_ready;
      want   = bus5.modo ? (bus5.e_valid != 5'b0) :
               ((bus5.sel < 3'd5) ? bus5.e_valid[bus5.sel] : 1'b0);
      tests++; if ((bus5.e_ready != 5'b0) !== (accept && want)) begin fails++;
        $display("FAIL soak_grant c=%0d: got rdy=%b expected grant=%b", c, bus5.e_ready,
                 accept && want); end
      tests++; if (bus5.sal_valid !== (exp_idx.size() != 0)) begin fails++;
        $display("FAIL soak_valid c=%0d: got %b expected %b", c, bus5.sal_valid,
                 exp_idx.size() != 0); end
      if (bus5.sal_valid === 1'b1 && exp_idx.size() != 0) begin
        tests++; if (bus5.sal_idx !== 3'(exp_idx[0]) || bus5.sal !== exp_dat[0]) begin fails++;
          $display("FAIL soak_word c=%0d: got i=%0d d=%h expected i=%0d d=%h", c, bus5.sal_idx,
                   bus5.sal, exp_idx[0], exp_dat[0]); end
      end
      hs = bus5.e_valid & bus5.e_ready;
      if (bus5.sal_valid && bus5.sal_ready && exp_idx.size() != 0) begin
        void'(exp_idx.pop_front());
        void'(exp_dat.pop_front());
      end
      for (int i = 0; i < 5; i++) if (!bus5.e_valid[i] || !bus5.modo) waits[i] = 0;
      if (hs != 5'b0) begin
        j = 0;
        for (int i = 0; i < 5; i++) if (hs[i]) j = i;
        exp_idx.push_back(j);
        exp_dat.push_back(bus5.e_data[j*8 +: 8]);
        if (bus5.modo) begin
          for (int i = 0; i < 5; i++) begin
            if (i != j && bus5.e_valid[i]) begin
              waits[i]++;
              tests++; if (waits[i] > 4) begin fails++;
                $display("FAIL soak_starve c=%0d ch=%0d: got %0d waits expected at most 4",
                         c, i, waits[i]); end
            end
          end
        end
        waits[j] = 0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) bus4.e_data[i*32 +: 32] = 32'hCAFE0000 + 32'(i);
    for (int i = 0; i < 3; i++) bus3.e_data[i*16 +: 16] = 16'hB000 + 16'(i);
    bus5.e_data = '0;
    bus4.e_valid = '0; bus4.modo = 1'b0; bus4.sel = '0; bus4.sal_ready = 1'b1;
    bus3.e_valid = '0; bus3.modo = 1'b0; bus3.sel = '0; bus3.sal_ready = 1'b1;
    bus5.e_valid = '0; bus5.modo = 1'b0; bus5.sel = '0; bus5.sal_ready = 1'b1;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_wrap_mode_switch();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
